// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store sequencer between the execute stage and the L1 data cache.
//   An accepted request is turned into one or more cache beats. Aligned
//   accesses use a single beat with byte enables 0001/0011/1111. A misaligned
//   halfword or word is split into 2 or 4 single-byte beats at A, A+1, ...
//   Each beat is held on the cache port until cache_hit_i. After the last hit
//   the load result is assembled and sign/zero-extended.
//
// Handshake: a beat is offered while cache_byte_en_o != 0. It is consumed on
//   any rising edge where cache_hit_i=1. mem_req_i is consumed only in IDLE.
//   Every request ends in exactly one done_o pulse or one err_o pulse, unless
//   rst aborts it.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   mem_req_i         request from execute (sampled in IDLE only)
//   mem_wr_i          1 = store, 0 = load
//   funct3_i          RV32I load/store funct3
//   addr_i            byte address
//   store_data_i      right-justified store data
//   cache_addr_o      beat address to L1
//   cache_wr_en_o     beat write enable to L1
//   cache_wr_data_o   beat write data to L1
//   cache_byte_en_o   beat byte enables to L1 (0000 when no beat)
//   cache_rd_data_i   L1 read data (a byte beat returns its byte in [7:0])
//   cache_hit_i       L1 hit, completes the current beat
//   busy_o            stall, high in ACCESS and DONE
//   done_o            1-cycle completion pulse
//   load_data_o       extended load result, held until the next load completes
//   err_o             1-cycle pulse: illegal funct3 or beat timeout
//   state_dbg_o       current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
module mem_access_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mem_req_i,
   input  logic                    mem_wr_i,
   input  logic [2:0]              funct3_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   store_data_i,
   output logic [ADDR_WIDTH-1:0]   cache_addr_o,
   output logic                    cache_wr_en_o,
   output logic [DATA_WIDTH-1:0]   cache_wr_data_o,
   output logic [3:0]              cache_byte_en_o,
   input  logic [DATA_WIDTH-1:0]   cache_rd_data_i,
   input  logic                    cache_hit_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [DATA_WIDTH-1:0]   load_data_o,
   output logic                    err_o,
   output logic [1:0]              state_dbg_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [2:0]              f3_q, f3_d;
   logic                    wr_q, wr_d;
   logic                    byte_mode_q, byte_mode_d;
   logic [1:0]              last_idx_q, last_idx_d;
   logic [1:0]              beat_idx_q, beat_idx_d;
   logic [7:0]              wait_q, wait_d;
   logic [DATA_WIDTH-1:0]   asm_q, asm_d;
   logic [ADDR_WIDTH-1:0]   c_addr_q, c_addr_d;
   logic                    c_wr_en_q, c_wr_en_d;
   logic [DATA_WIDTH-1:0]   c_wr_data_q, c_wr_data_d;
   logic [3:0]              c_byte_en_q, c_byte_en_d;
   logic                    done_q, done_d;
   logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;
   logic                    err_q, err_d;

   // Request decode (only meaningful in IDLE)
   logic       req_legal;
   logic       req_misaligned;
   logic [1:0] req_size;

   function automatic logic [DATA_WIDTH-1:0] extend(input logic [2:0] f3,
                                                    input logic [DATA_WIDTH-1:0] v);
      logic [DATA_WIDTH-1:0] r;
      case (f3)
         3'b000:  r = {{(DATA_WIDTH-8){v[7]}}, v[7:0]};
         3'b001:  r = {{(DATA_WIDTH-16){v[15]}}, v[15:0]};
         3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, v[7:0]};
         3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, v[15:0]};
         default: r = v;
      endcase
      return r;
   endfunction

   always_comb begin
      req_size       = funct3_i[1:0];
      req_legal      = 1'b0;
      req_misaligned = 1'b0;
      case (funct3_i)
         3'b000, 3'b001, 3'b010: req_legal = 1'b1;
         3'b100, 3'b101:         req_legal = !mem_wr_i;
         default:                req_legal = 1'b0;
      endcase
      if (req_size == 2'b01) req_misaligned = addr_i[0];
      if (req_size == 2'b10) req_misaligned = (addr_i[1:0] != 2'b00);
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      f3_d        = f3_q;
      wr_d        = wr_q;
      byte_mode_d = byte_mode_q;
      last_idx_d  = last_idx_q;
      beat_idx_d  = beat_idx_q;
      wait_d      = wait_q;
      asm_d       = asm_q;
      c_addr_d    = c_addr_q;
      c_wr_en_d   = c_wr_en_q;
      c_wr_data_d = c_wr_data_q;
      c_byte_en_d = c_byte_en_q;
      done_d      = 1'b0;
      load_data_d = load_data_q;
      err_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (mem_req_i) begin
               if (!req_legal) begin
                  err_d = 1'b1;
               end else begin
                  state_d     = S_ACCESS;
                  addr_d      = addr_i;
                  data_d      = store_data_i;
                  f3_d        = funct3_i;
                  wr_d        = mem_wr_i;
                  beat_idx_d  = 2'd0;
                  wait_d      = 8'd0;
                  asm_d       = '0;
                  byte_mode_d = (req_size == 2'b00) || req_misaligned;
                  // Misaligned half -> 2 byte beats, misaligned word -> 4
                  if (req_misaligned) last_idx_d = (req_size == 2'b01) ? 2'd1 : 2'd3;
                  else                last_idx_d = 2'd0;
                  c_addr_d  = addr_i;
                  c_wr_en_d = mem_wr_i;
                  if ((req_size == 2'b00) || req_misaligned) begin
                     c_byte_en_d = 4'b0001;
                     c_wr_data_d = {{(DATA_WIDTH-8){1'b0}}, store_data_i[7:0]};
                  end else if (req_size == 2'b01) begin
                     c_byte_en_d = 4'b0011;
                     c_wr_data_d = {{(DATA_WIDTH-16){1'b0}}, store_data_i[15:0]};
                  end else begin
                     c_byte_en_d = 4'b1111;
                     c_wr_data_d = store_data_i;
                  end
               end
            end
         end

         S_ACCESS: begin
            if (cache_hit_i) begin
               wait_d = 8'd0;
               // Byte beats return their byte in rd_data[7:0]; place it in lane k
               if (byte_mode_q)                asm_d[{beat_idx_q, 3'b000} +: 8] = cache_rd_data_i[7:0];
               else if (c_byte_en_q == 4'b1111) asm_d = cache_rd_data_i;
               else                            asm_d[15:0] = cache_rd_data_i[15:0];

               if (beat_idx_q == last_idx_q) begin
                  state_d     = S_DONE;
                  c_byte_en_d = 4'b0000;
                  c_wr_en_d   = 1'b0;
                  done_d      = 1'b1;
                  if (!wr_q) load_data_d = extend(f3_q, asm_d);
               end else begin
                  beat_idx_d  = beat_idx_q + 2'd1;
                  c_addr_d    = addr_q + ADDR_WIDTH'(beat_idx_d);
                  c_wr_data_d = {{(DATA_WIDTH-8){1'b0}}, data_q[{beat_idx_d, 3'b000} +: 8]};
               end
            end else if (wait_q == WAIT_LAST) begin
               // Beat has been offered MAX_WAIT cycles without a hit: abort
               state_d     = S_IDLE;
               c_byte_en_d = 4'b0000;
               c_wr_en_d   = 1'b0;
               wait_d      = 8'd0;
               err_d       = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d     = S_IDLE;
            c_byte_en_d = 4'b0000;
            c_wr_en_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         f3_q        <= '0;
         wr_q        <= 1'b0;
         byte_mode_q <= 1'b0;
         last_idx_q  <= '0;
         beat_idx_q  <= '0;
         wait_q      <= '0;
         asm_q       <= '0;
         c_addr_q    <= '0;
         c_wr_en_q   <= 1'b0;
         c_wr_data_q <= '0;
         c_byte_en_q <= '0;
         done_q      <= 1'b0;
         load_data_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         f3_q        <= f3_d;
         wr_q        <= wr_d;
         byte_mode_q <= byte_mode_d;
         last_idx_q  <= last_idx_d;
         beat_idx_q  <= beat_idx_d;
         wait_q      <= wait_d;
         asm_q       <= asm_d;
         c_addr_q    <= c_addr_d;
         c_wr_en_q   <= c_wr_en_d;
         c_wr_data_q <= c_wr_data_d;
         c_byte_en_q <= c_byte_en_d;
         done_q      <= done_d;
         load_data_q <= load_data_d;
         err_q       <= err_d;
      end
   end

   assign cache_addr_o    = c_addr_q;
   assign cache_wr_en_o   = c_wr_en_q;
   assign cache_wr_data_o = c_wr_data_q;
   assign cache_byte_en_o = c_byte_en_q;
   assign busy_o          = (state_q == S_ACCESS) || (state_q == S_DONE);
   assign done_o          = done_q;
   assign load_data_o     = load_data_q;
   assign err_o           = err_q;
   assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed tests for mem_access_unit with hand-computed expected values.
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_i, mem_wr_i, cache_hit_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i, store_data_i, cache_rd_data_i;
   logic [31:0] cache_addr_o, cache_wr_data_o, load_data_o;
   logic        cache_wr_en_o, busy_o, done_o, err_o;
   logic [3:0]  cache_byte_en_o;
   logic [1:0]  state_dbg_o;

   int checks   = 0;
   int failures = 0;

   mem_access_unit dut (
      .clk(clk), .rst(rst),
      .mem_req_i(mem_req_i), .mem_wr_i(mem_wr_i), .funct3_i(funct3_i),
      .addr_i(addr_i), .store_data_i(store_data_i),
      .cache_addr_o(cache_addr_o), .cache_wr_en_o(cache_wr_en_o),
      .cache_wr_data_o(cache_wr_data_o), .cache_byte_en_o(cache_byte_en_o),
      .cache_rd_data_i(cache_rd_data_i), .cache_hit_i(cache_hit_i),
      .busy_o(busy_o), .done_o(done_o), .load_data_o(load_data_o),
      .err_o(err_o), .state_dbg_o(state_dbg_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one cycle; returns in cycle 1 with mem_req_i low.
   task automatic issue(input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      mem_req_i = 1'b1; mem_wr_i = wr; funct3_i = f3; addr_i = a; store_data_i = d;
      step();
      mem_req_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_req_i = 0; mem_wr_i = 0; funct3_i = 0; addr_i = 0; store_data_i = 0;
      cache_rd_data_i = 0; cache_hit_i = 0;
      #2;
      checks++;
      if ({cache_byte_en_o, cache_wr_en_o, busy_o, done_o, err_o, state_dbg_o} !== 10'd0 ||
          cache_addr_o !== 32'd0 || load_data_o !== 32'd0 || cache_wr_data_o !== 32'd0) begin
         failures++; $display("FAIL reset_outputs got en=%h busy=%b done=%b err=%b ld=%h exp all 0",
                              cache_byte_en_o, busy_o, done_o, err_o, load_data_o);
      end
      step(); step();
      rst = 1'b0;
      step();
      checks++;
      if (busy_o !== 1'b0 || state_dbg_o !== 2'd0) begin
         failures++; $display("FAIL reset_release got busy=%b state=%0d exp 0/0", busy_o, state_dbg_o);
      end
   endtask

   task automatic test_lw();
      issue(1'b0, 3'b010, 32'h100, 32'h0);
      checks++;
      if (cache_byte_en_o !== 4'b1111 || cache_addr_o !== 32'h100 || cache_wr_en_o !== 1'b0 ||
          busy_o !== 1'b1 || done_o !== 1'b0) begin
         failures++; $display("FAIL lw_beat got en=%h addr=%h wr=%b busy=%b done=%b exp 1111/100/0/1/0",
                              cache_byte_en_o, cache_addr_o, cache_wr_en_o, busy_o, done_o);
      end
      cache_rd_data_i = 32'h8899AABB; cache_hit_i = 1'b1;
      step();
      cache_hit_i = 1'b0;
      checks++;
      if (done_o !== 1'b1 || load_data_o !== 32'h8899AABB || cache_byte_en_o !== 4'b0000 || busy_o !== 1'b1) begin
         failures++; $display("FAIL lw_done got done=%b ld=%h en=%h busy=%b exp 1/8899aabb/0000/1",
                              done_o, load_data_o, cache_byte_en_o, busy_o);
      end
      step();
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || load_data_o !== 32'h8899AABB) begin
         failures++; $display("FAIL lw_idle got done=%b busy=%b ld=%h exp 0/0/8899aabb", done_o, busy_o, load_data_o);
      end
   endtask

   task automatic test_byte_loads();
      logic [2:0]  f3 [2];
      logic [31:0] exp_ld [2];
      f3[0] = 3'b000; exp_ld[0] = 32'hFFFFFF80;
      f3[1] = 3'b100; exp_ld[1] = 32'h00000080;
      for (int i = 0; i < 2; i++) begin
         issue(1'b0, f3[i], 32'h101, 32'h0);
         checks++;
         if (cache_byte_en_o !== 4'b0001 || cache_addr_o !== 32'h101) begin
            failures++; $display("FAIL byte_beat[%0d] got en=%h addr=%h exp 0001/101", i, cache_byte_en_o, cache_addr_o);
         end
         cache_rd_data_i = 32'h00000080; cache_hit_i = 1'b1;
         step();
         cache_hit_i = 1'b0;
         checks++;
         if (done_o !== 1'b1 || load_data_o !== exp_ld[i]) begin
            failures++; $display("FAIL byte_load[%0d] got done=%b ld=%h exp 1/%h", i, done_o, load_data_o, exp_ld[i]);
         end
         step();
      end
   endtask

   task automatic test_aligned_half();
      logic [2:0]  f3 [2];
      logic [31:0] exp_ld [2];
      f3[0] = 3'b001; exp_ld[0] = 32'hFFFFF00D;
      f3[1] = 3'b101; exp_ld[1] = 32'h0000F00D;
      for (int i = 0; i < 2; i++) begin
         issue(1'b0, f3[i], 32'h502, 32'h0);
         checks++;
         if (cache_byte_en_o !== 4'b0011 || cache_addr_o !== 32'h502) begin
            failures++; $display("FAIL half_beat[%0d] got en=%h addr=%h exp 0011/502", i, cache_byte_en_o, cache_addr_o);
         end
         cache_rd_data_i = 32'h5555F00D; cache_hit_i = 1'b1;
         step();
         cache_hit_i = 1'b0;
         checks++;
         if (done_o !== 1'b1 || load_data_o !== exp_ld[i]) begin
            failures++; $display("FAIL half_load[%0d] got done=%b ld=%h exp 1/%h", i, done_o, load_data_o, exp_ld[i]);
         end
         step();
      end
   endtask

   // Misaligned access; n byte beats starting at a, with per-beat expectations.
   task automatic run_split(input string name, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d, input int n,
                            input logic [31:0] exp_addr [4], input logic [7:0] beat_byte [4],
                            input logic [31:0] exp_ld);
      issue(wr, f3, a, d);
      for (int k = 0; k < n; k++) begin
         checks++;
         if (cache_byte_en_o !== 4'b0001 || cache_addr_o !== exp_addr[k] || cache_wr_en_o !== wr ||
             (wr && cache_wr_data_o !== {24'd0, beat_byte[k]})) begin
            failures++; $display("FAIL %s_beat%0d got en=%h addr=%h wr=%b wd=%h exp 0001/%h/%b/%h", name, k,
                                 cache_byte_en_o, cache_addr_o, cache_wr_en_o, cache_wr_data_o,
                                 exp_addr[k], wr, {24'd0, beat_byte[k]});
         end
         cache_rd_data_i = wr ? 32'hFFFFFFFF : {24'h5A5A5A, beat_byte[k]};
         cache_hit_i = 1'b1;
         step();
         cache_hit_i = 1'b0;
      end
      checks++;
      if (done_o !== 1'b1 || load_data_o !== exp_ld || cache_byte_en_o !== 4'b0000 || cache_wr_en_o !== 1'b0) begin
         failures++; $display("FAIL %s_done got done=%b ld=%h en=%h wr=%b exp 1/%h/0000/0", name,
                              done_o, load_data_o, cache_byte_en_o, cache_wr_en_o, exp_ld);
      end
      step();
   endtask

   task automatic test_lh_misaligned();
      logic [31:0] ea [4];
      logic [7:0]  bb [4];
      ea[0] = 32'h203; ea[1] = 32'h204; ea[2] = 0; ea[3] = 0;
      bb[0] = 8'h34;   bb[1] = 8'h92;   bb[2] = 0; bb[3] = 0;
      run_split("lh_mis", 1'b0, 3'b001, 32'h203, 32'h0, 2, ea, bb, 32'hFFFF9234);
   endtask

   task automatic test_sw_misaligned();
      logic [31:0] ea [4];
      logic [7:0]  bb [4];
      ea[0] = 32'h302; ea[1] = 32'h303; ea[2] = 32'h304; ea[3] = 32'h305;
      bb[0] = 8'h34;   bb[1] = 8'h12;   bb[2] = 8'hAD;   bb[3] = 8'hDE;
      // load_data keeps the previous load result (LH above)
      run_split("sw_mis", 1'b1, 3'b010, 32'h302, 32'hDEAD1234, 4, ea, bb, 32'hFFFF9234);
   endtask

   task automatic test_wrap();
      logic [31:0] ea [4];
      logic [7:0]  bb [4];
      ea[0] = 32'hFFFFFFFE; ea[1] = 32'hFFFFFFFF; ea[2] = 32'h0; ea[3] = 32'h1;
      bb[0] = 8'h11;        bb[1] = 8'h22;        bb[2] = 8'h33; bb[3] = 8'h44;
      run_split("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 4, ea, bb, 32'h44332211);
   endtask

   task automatic test_miss_wait();
      issue(1'b0, 3'b010, 32'h400, 32'h0);
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (cache_byte_en_o !== 4'b1111 || cache_addr_o !== 32'h400 || done_o !== 1'b0 || busy_o !== 1'b1) begin
            failures++; $display("FAIL miss_hold%0d got en=%h addr=%h done=%b busy=%b exp 1111/400/0/1",
                                 c, cache_byte_en_o, cache_addr_o, done_o, busy_o);
         end
      end
      cache_rd_data_i = 32'h12345678; cache_hit_i = 1'b1;
      step();
      cache_hit_i = 1'b0;
      checks++;
      if (done_o !== 1'b1 || load_data_o !== 32'h12345678) begin
         failures++; $display("FAIL miss_done got done=%b ld=%h exp 1/12345678", done_o, load_data_o);
      end
      step();
   endtask

   task automatic test_timeout();
      int cyc;
      issue(1'b0, 3'b010, 32'h600, 32'h0);
      cyc = 1;
      while (err_o !== 1'b1 && cyc < 400) begin
         step();
         cyc++;
      end
      checks++;
      if (cyc != 256 || busy_o !== 1'b0 || done_o !== 1'b0 || cache_byte_en_o !== 4'b0000) begin
         failures++; $display("FAIL timeout got cycle=%0d busy=%b done=%b en=%h exp 256/0/0/0000",
                              cyc, busy_o, done_o, cache_byte_en_o);
      end
      step();
      checks++;
      if (err_o !== 1'b0 || state_dbg_o !== 2'd0) begin
         failures++; $display("FAIL timeout_pulse got err=%b state=%0d exp 0/0", err_o, state_dbg_o);
      end
   endtask

   task automatic test_illegal();
      logic [2:0] f3 [5];
      logic       wr [5];
      f3[0] = 3'b011; wr[0] = 0;
      f3[1] = 3'b110; wr[1] = 0;
      f3[2] = 3'b111; wr[2] = 1;
      f3[3] = 3'b100; wr[3] = 1;
      f3[4] = 3'b101; wr[4] = 1;
      for (int i = 0; i < 5; i++) begin
         issue(wr[i], f3[i], 32'h700, 32'h0);
         checks++;
         if (err_o !== 1'b1 || cache_byte_en_o !== 4'b0000 || busy_o !== 1'b0 || state_dbg_o !== 2'd0) begin
            failures++; $display("FAIL illegal[%0d] got err=%b en=%h busy=%b state=%0d exp 1/0000/0/0",
                                 i, err_o, cache_byte_en_o, busy_o, state_dbg_o);
         end
         step();
         checks++;
         if (err_o !== 1'b0) begin
            failures++; $display("FAIL illegal_pulse[%0d] got err=%b exp 0", i, err_o);
         end
      end
   endtask

   task automatic test_hit_idle();
      cache_hit_i = 1'b1; cache_rd_data_i = 32'hCAFEF00D;
      step(); step();
      cache_hit_i = 1'b0;
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || cache_byte_en_o !== 4'b0000 || err_o !== 1'b0) begin
         failures++; $display("FAIL hit_idle got done=%b busy=%b en=%h err=%b exp 0/0/0000/0",
                              done_o, busy_o, cache_byte_en_o, err_o);
      end
   endtask

   task automatic test_reset_mid();
      issue(1'b1, 3'b010, 32'h801, 32'hA1B2C3D4);
      cache_hit_i = 1'b1;
      step();
      cache_hit_i = 1'b0;
      checks++;
      if (cache_addr_o !== 32'h802 || cache_wr_data_o !== 32'h000000C3) begin
         failures++; $display("FAIL rstmid_beat2 got addr=%h wd=%h exp 802/c3", cache_addr_o, cache_wr_data_o);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (cache_byte_en_o !== 4'b0000 || cache_wr_en_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
          err_o !== 1'b0 || state_dbg_o !== 2'd0 || load_data_o !== 32'd0 || cache_addr_o !== 32'd0) begin
         failures++; $display("FAIL rstmid_async got en=%h wr=%b busy=%b done=%b err=%b state=%0d exp all 0",
                              cache_byte_en_o, cache_wr_en_o, busy_o, done_o, err_o, state_dbg_o);
      end
      step();
      rst = 1'b0;
      step();
      checks++;
      if (done_o !== 1'b0 || err_o !== 1'b0 || state_dbg_o !== 2'd0) begin
         failures++; $display("FAIL rstmid_after got done=%b err=%b state=%0d exp 0/0/0", done_o, err_o, state_dbg_o);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_byte_loads();
      test_aligned_half();
      test_lh_misaligned();
      test_sw_misaligned();
      test_wrap();
      test_miss_wait();
      test_timeout();
      test_illegal();
      test_hit_idle();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
